// File: rtl/fp16_quant_pkg.sv
// Shared types and constants for the FP16 -> INT4 group quantizer.
// The scale helper maps the group's largest biased exponent to the FP16 scale word.
package fp16_quant_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;
    localparam int INT4_MAX   = 7;
    localparam int INT4_MIN   = -8;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } quant_state_e;

    // Scale is 2^(emax-17); emax 1 and 2 land in the FP16 subnormal range.
    function automatic logic [15:0] scale_from_emax(input logic [FP16_EXP_W-1:0] emax);
        logic [15:0] scale;
        case (emax)
            5'd0:    scale = 16'h0000;
            5'd1:    scale = 16'h0100;
            5'd2:    scale = 16'h0200;
            default: scale = {1'b0, emax - 5'd2, 10'b0};
        endcase
        return scale;
    endfunction

endpackage

// File: rtl/fp16_int4_quant_elem.sv
// Combinational quantizer for one FP16 element against the group's max exponent.
// Produces a saturated, round-half-away-from-zero signed INT4 code.
module fp16_int4_quant_elem
    import fp16_quant_pkg::*;
(
    input  fp16_t                 value,
    input  logic [FP16_EXP_W-1:0] emax,
    output logic [3:0]            code
);

    logic [FP16_EXP_W-1:0] d;
    logic [13:0]           mag;
    logic [13:0]           shifted;
    logic [14:0]           rounded;
    logic [3:0]            q;

    always_comb begin
        d       = emax - value.exp;
        // 1.m with three guard bits; integer part of v sits at bit 11 after the shift.
        mag     = {1'b1, value.man, 3'b000};
        shifted = mag >> d;
        rounded = {1'b0, shifted} + 15'd1024;
        q       = 4'(rounded >> 11);
        if (d >= 5'd4) begin
            q = 4'd0;
        end

        code = 4'd0;
        if (value.exp == '1) begin
            if (value.man == '0) begin
                code = value.sign ? 4'(INT4_MIN) : 4'(INT4_MAX);
            end
        end else if (value.exp != '0) begin
            if (value.sign) begin
                code = (q == 4'd8) ? 4'(INT4_MIN) : 4'(~q + 4'd1);
            end else begin
                code = (q == 4'd8) ? 4'(INT4_MAX) : q;
            end
        end
    end

endmodule

// File: rtl/fp16_int4_quant.sv
// Group-wise FP16 -> INT4 quantizer: buffers G elements while tracking the max
// exponent, then streams out codes with one shared power-of-two FP16 scale.
module fp16_int4_quant
    import fp16_quant_pkg::*;
#(
    parameter int G = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_fp16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_int4,
    output logic [15:0] out_scale,
    output logic        out_last
);

    localparam int IW = (G > 1) ? $clog2(G) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(G - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // the producer holds data stable while valid is high and ready is low.

    quant_state_e          state;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic [FP16_EXP_W-1:0] emax;
    fp16_t                 mem [G];
    fp16_t                 in_elem;
    logic [3:0]            elem_code;

    assign in_elem = in_fp16;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            wr_idx <= '0;
            rd_idx <= '0;
            emax   <= '0;
            for (int i = 0; i < G; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        mem[wr_idx] <= in_elem;
                        if (in_elem.exp > emax) begin
                            emax <= in_elem.exp;
                        end
                        if (wr_idx == LAST_IDX) begin
                            state  <= EMIT;
                            wr_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            state  <= FILL;
                            rd_idx <= '0;
                            emax   <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    fp16_int4_quant_elem u_elem (
        .value (mem[rd_idx]),
        .emax  (emax),
        .code  (elem_code)
    );

    // All outputs derive from registered state, so they hold while stalled.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == EMIT);
    assign out_last  = (state == EMIT) && (rd_idx == LAST_IDX);
    assign out_int4  = (state == EMIT) ? elem_code : 4'd0;
    assign out_scale = (state == EMIT) ? scale_from_emax(emax) : 16'h0000;

endmodule

// File: tb/tb_fp16_int4_quant.sv
// Directed bench for fp16_int4_quant: stimulus pushes hand-computed results into
// a queue, an independent monitor pops and compares on every output transfer.
module tb_fp16_int4_quant;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_fp16;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_int4;
    logic [15:0] out_scale;
    logic        out_last;

    int total = 0;
    int bad   = 0;
    int out_mode = 0;  // 0: always ready, 1: toggle, 2: never ready

    logic [20:0] exp_q[$];  // {code, scale, last}

    fp16_int4_quant #(.G(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp16   (in_fp16),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int4  (out_int4),
        .out_scale (out_scale),
        .out_last  (out_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Downstream ready pattern, updated just after each active edge.
    always begin
        @(posedge clk);
        #1;
        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic drive_one(input logic [15:0] v);
        int t;
        bit ok;
        in_valid = 1'b1;
        in_fp16  = v;
        t  = 0;
        ok = 1'b0;
        while (!ok && t <= 300) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_group(input logic [15:0] vals[8], input logic [3:0] codes[8],
                              input logic [15:0] scale, input int gaps, input bit push);
        if (push) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({codes[i], scale, (i == 7)});
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (gaps > 0) begin
                repeat ($urandom_range(0, gaps)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_one(vals[i]);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_queue_left", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  32'd1);
        check({tag, "_out_valid"}, out_valid, 32'd0);
        check({tag, "_out_int4"},  out_int4,  32'd0);
        check({tag, "_out_scale"}, out_scale, 32'd0);
        check({tag, "_out_last"},  out_last,  32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_stall = 1'b0;
    logic [20:0] prev_out   = '0;

    always begin
        logic [20:0] e;
        @(negedge clk);
        if (rst_n) begin
            if (out_valid) begin
                check("in_ready_in_emit", in_ready, 32'd0);
            end
            if (prev_stall && out_valid) begin
                check("stall_hold", {out_int4, out_scale, out_last}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {out_int4, out_scale, out_last}, 32'd0);
                    bad++;
                    total++;
                    $display("FAIL unexpected_output: got an element with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    check("code",  out_int4,  e[20:17]);
                    check("scale", out_scale, e[16:1]);
                    check("last",  out_last,  e[0]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_int4, out_scale, out_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] v[8];
    logic [3:0]  c[8];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fp16   = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // mixed-sign group, emax 16
        v = '{16'h3C00, 16'h4000, 16'hBE00, 16'h0000, 16'h3800, 16'hC000, 16'h3C00, 16'h3800};
        c = '{4'd2, 4'd4, 4'hD, 4'd0, 4'd1, 4'hC, 4'd2, 4'd1};
        send_group(v, c, 16'h3800, 0, 1'b1);

        // rounding up to 8 saturates to 7 / -8
        v = '{16'h4700, 16'h47E6, 16'hC7E6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        c = '{4'd7, 4'd7, 4'h8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        send_group(v, c, 16'h3C00, 0, 1'b1);

        // all zero
        v = '{default: 16'h0000};
        c = '{default: 4'd0};
        send_group(v, c, 16'h0000, 0, 1'b1);

        // Inf / -Inf / NaN
        v = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        c = '{4'd7, 4'h8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        send_group(v, c, 16'h7400, 0, 1'b1);

        // d=3 half rounds away from zero, d=4 flushes, 2.5 rounds to 3
        v = '{16'h4000, 16'h3400, 16'h3000, 16'hB400, 16'h3C00, 16'h3D00, 16'h0000, 16'h0000};
        c = '{4'd4, 4'd1, 4'd0, 4'hF, 4'd2, 4'd3, 4'd0, 4'd0};
        send_group(v, c, 16'h3800, 0, 1'b1);

        // emax 1: subnormal scale, subnormal input flushed
        v = '{16'h0400, 16'h0200, 16'h8400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        c = '{4'd4, 4'd0, 4'hC, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        send_group(v, c, 16'h0100, 0, 1'b1);

        // emax 2
        v = '{16'h0800, 16'h0400, 16'h0600, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        c = '{4'd4, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        send_group(v, c, 16'h0200, 0, 1'b1);

        // backpressure on the output, gaps on the input
        out_mode = 1;
        v = '{16'h3C00, 16'h4000, 16'hBE00, 16'h0000, 16'h3800, 16'hC000, 16'h3C00, 16'h3800};
        c = '{4'd2, 4'd4, 4'hD, 4'd0, 4'd1, 4'hC, 4'd2, 4'd1};
        send_group(v, c, 16'h3800, 2, 1'b1);
        v = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        c = '{4'd7, 4'h8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        send_group(v, c, 16'h7400, 3, 1'b1);
        wait_drain();
        out_mode = 0;

        // reset after 5 large inputs; the fresh group must not see their exponent
        for (int i = 0; i < 5; i++) drive_one(16'h7800);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_fill");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{16'h3C00, 16'h4000, 16'hBE00, 16'h0000, 16'h3800, 16'hC000, 16'h3C00, 16'h3800};
        c = '{4'd2, 4'd4, 4'hD, 4'd0, 4'd1, 4'hC, 4'd2, 4'd1};
        send_group(v, c, 16'h3800, 0, 1'b1);
        wait_drain();

        // reset while a group is stalled in EMIT
        out_mode = 2;
        @(posedge clk);
        #1;
        v = '{16'h4700, 16'h47E6, 16'hC7E6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        c = '{default: 4'd0};
        send_group(v, c, 16'h3C00, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("emit_before_reset", out_valid, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_emit");
        @(negedge clk);
        rst_n = 1'b1;
        out_mode = 0;
        @(posedge clk);
        #1;
        v = '{default: 16'h0000};
        c = '{default: 4'd0};
        send_group(v, c, 16'h0000, 0, 1'b1);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
